// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes, funct codes, ALU codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_IMMWB, S_JUMP, S_LOGIEX
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop classes handed from the FSM to the ALU decoder
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_LOGIC = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: {aluop, funct, immediate-logic op} -> 3-bit alu_control, flags unknown R-type funct.
// Purely combinational, no backpressure.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  input  logic       logic_or_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_funct_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (aluop_i)
      AOP_SUB: alu_control_o = ALU_SUB;
      AOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_NOR:  alu_control_o = ALU_NOR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      AOP_LOGIC: alu_control_o = logic_or_i ? ALU_OR : ALU_AND;
      default:   alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS-subset core; MULTICYCLE_CTRL_IMM_LOGIC_EN adds ORI/ANDI.
// Outputs decode from the state register; R 4, LW 5, SW 4, BEQ/BNE 3, ADDI 4, J 3 cycles at full speed.
// FETCH, MEMRD and MEMWR hold until mem_ready; reset forces all enables low asynchronously.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       zero_ext,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       logic_or;
  logic [2:0] dec_alu_control;
  logic       illegal_funct;

  alu_decoder u_alu_decoder (
    .aluop_i         (aluop),
    .funct_i         (funct),
    .logic_or_i      (logic_or),
    .alu_control_o   (dec_alu_control),
    .illegal_funct_o (illegal_funct)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    zero_ext   = 1'b0;
    illegal    = 1'b0;
    aluop      = AOP_ADD;
    logic_or   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // branch target computed speculatively into ALUOut
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_IMM_LOGIC_EN
          OP_ORI, OP_ANDI: state_d = S_LOGIEX;
`else
          OP_ORI, OP_ANDI: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = AOP_FUNCT;
        illegal   = illegal_funct;
        state_d   = illegal_funct ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = AOP_SUB;
        pc_src    = 2'b01;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_IMM_LOGIC_EN
      S_LOGIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        zero_ext  = 1'b1;
        aluop     = AOP_LOGIC;
        logic_or  = (opcode == OP_ORI);
        state_d   = S_IMMWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    alu_control = dec_alu_control;

    // reset overrides combinationally so an in-flight write drops immediately
    if (!rstn) begin
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      zero_ext    = 1'b0;
      illegal     = 1'b0;
      alu_control = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction phase lists drive expectations into a queue.
module tb_multicycle_ctrl;

  logic       clk, rstn;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, zero_ext, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  multicycle_ctrl dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
    .zero_ext(zero_ext), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [17:0] dut_v = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_control, pc_src, zero_ext, illegal};

  localparam int P_RST = -1, P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_AX = 9, P_IWB = 10, P_J = 11, P_LX = 12;

  typedef struct {
    logic [17:0] v;
    int          ph;
    logic [5:0]  op;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010: return 1'b1;
`ifdef MULTICYCLE_CTRL_IMM_LOGIC_EN
      6'b001101, 6'b001100: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit fn_alu(input logic [5:0] fn, output logic [2:0] alu);
    alu = 3'b010;
    case (fn)
      6'b100000: alu = 3'b010;
      6'b100010: alu = 3'b110;
      6'b100100: alu = 3'b000;
      6'b100101: alu = 3'b001;
      6'b100111: alu = 3'b101;
      6'b101010: alu = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Expected control word for one cycle of a given instruction phase
  function automatic logic [17:0] expected(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic mr);
    logic pe = 0, io = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ze = 0, il = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] alu = 3'b010;
    logic [2:0] fa;
    case (ph)
      P_F:   begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
      P_D:   begin sb = 2'b11; il = !op_legal(op); end
      P_MA:  begin sa = 1; sb = 2'b10; end
      P_MR:  begin mrd = 1; io = 1; end
      P_MWB: begin m2r = 1; rw = 1; end
      P_MW:  begin mwr = 1; io = 1; end
      P_EX:  begin sa = 1; il = !fn_alu(fn, fa); alu = fa; end
      P_AWB: begin rd = 1; rw = 1; end
      P_BR:  begin sa = 1; alu = 3'b110; ps = 2'b01; pe = (op == 6'b000100) ? z : !z; end
      P_AX:  begin sa = 1; sb = 2'b10; end
      P_IWB: rw = 1;
      P_J:   begin ps = 2'b10; pe = 1; end
      P_LX:  begin sa = 1; sb = 2'b10; ze = 1; alu = (op == 6'b001101) ? 3'b001 : 3'b000; end
      default: ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, alu, ps, ze, il};
  endfunction

  always @(negedge clk) begin
    if (rstn && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("op%06b_phase%0d", mon_e.op, mon_e.ph), dut_v, mon_e.v);
    end
  end

  // One instruction: zmode<0 randomises zero; abort pulls reset during the first MEMWR cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                           input int mwait, input int zmode, input bit abort);
    int   ph[$];
    int   waits;
    logic [2:0] dummy;
    exp_t e;
    ph = {P_F, P_D};
    if (op_legal(op)) begin
      case (op)
        6'b000000: begin ph.push_back(P_EX); if (fn_alu(fn, dummy)) ph.push_back(P_AWB); end
        6'b100011: ph = {ph, P_MA, P_MR, P_MWB};
        6'b101011: ph = {ph, P_MA, P_MW};
        6'b000100, 6'b000101: ph.push_back(P_BR);
        6'b001000: ph = {ph, P_AX, P_IWB};
        6'b000010: ph.push_back(P_J);
        default:   ph = {ph, P_LX, P_IWB};
      endcase
    end
    foreach (ph[k]) begin
      waits = (ph[k] == P_F) ? fwait : (ph[k] == P_MR || ph[k] == P_MW) ? mwait : 0;
      for (int w = 0; w <= waits; w++) begin
        opcode = op;
        funct  = fn;
        zero   = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        if (ph[k] == P_F || ph[k] == P_MR || ph[k] == P_MW) mem_ready = (w == waits);
        else mem_ready = 1'($urandom);
        if (abort && ph[k] == P_MW) mem_ready = 1'b0;
        e.v  = expected(ph[k], op, fn, zero, mem_ready);
        e.ph = ph[k];
        e.op = op;
        exp_q.push_back(e);
        if (abort && ph[k] == P_MW) begin
          @(negedge clk); #1;
          rstn = 1'b0;
          #1;
          chk("reset_during_memwr", dut_v, expected(P_RST, op, fn, zero, mem_ready));
          repeat (2) @(posedge clk);
          @(negedge clk);
          mem_ready = 1'b0;
          rstn = 1'b1;
          #1;
          chk("fetch_after_release", dut_v, expected(P_F, op, fn, zero, 1'b0));
          @(posedge clk); #1;
          return;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  logic [5:0] op_tab [10];
  logic [5:0] fn_tab [6];

  initial begin
    logic [5:0] op, fn;
    op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
               6'b001000, 6'b000010, 6'b001101, 6'b001100, 6'b000000};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    rstn = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #22;
    chk("reset_outputs", dut_v, expected(P_RST, 6'b0, 6'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    run_instr(6'b000000, 6'b100010, 0, 0, -1, 0);   // SUB
    run_instr(6'b100011, 6'b000000, 0, 3, -1, 0);   // LW with 3 MEMRD waits
    run_instr(6'b000100, 6'b000000, 0, 0, 1, 0);    // BEQ taken
    run_instr(6'b000101, 6'b000000, 0, 0, 1, 0);    // BNE not taken
    run_instr(6'b000101, 6'b000000, 0, 0, 0, 0);    // BNE taken
    run_instr(6'b111111, 6'b000000, 0, 0, -1, 0);   // illegal opcode
    run_instr(6'b001101, 6'b000000, 0, 0, -1, 0);   // ORI
    run_instr(6'b001100, 6'b000000, 1, 0, -1, 0);   // ANDI
    run_instr(6'b000000, 6'b111000, 0, 0, -1, 0);   // unknown funct
    run_instr(6'b101011, 6'b000000, 0, 2, -1, 1);   // SW aborted by reset
    run_instr(6'b000010, 6'b000000, 0, 0, -1, 0);   // J

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : op_tab[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
      run_instr(op, fn,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                -1, 0);
    end

    @(negedge clk); #2;
    chk("scoreboard_drained", 18'(exp_q.size()), 18'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
